// File: rtl/design_sel_ctrl.sv
// ---------------------------------------------------------------------------
// design_sel_ctrl
//
// Drives the design-selection strobe interface (sel_id / sel_clk) that feeds
// the IO pad mux. The mux latches sel_id on each rising edge of sel_clk.
//
// A request is switched in two pulses so the pads never see a half-selected
// design. The first pulse latches SAFE_ID, which turns every pad into an
// input. The block then waits a guard interval. The second pulse latches the
// requested ID. design_rst is held high for the whole switch.
//
// Ports
//   wb_clk_i   : sole clock, rising edge
//   wb_rst_i   : synchronous active-high reset
//   req_valid  : select request valid
//   req_id     : requested design ID
//   req_ready  : high only in IDLE; accept on req_valid && req_ready
//   sel_id     : ID presented to the mux
//   sel_clk    : latch strobe to the mux
//   design_rst : reset to user designs while switching
//   busy       : high whenever the FSM is not idle
//   cur_id     : last ID committed by a completed sequence
//   cur_valid  : cur_id is known (cleared by reset)
//   done       : one-cycle pulse on sequence completion
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_id is captured on that edge. While busy,
// req_valid is ignored and is not queued.
// ---------------------------------------------------------------------------
module design_sel_ctrl #(
   parameter int          SETUP_CYCLES = 2,
   parameter int          PULSE_CYCLES = 2,
   parameter int          GUARD_CYCLES = 16,
   parameter logic [3:0]  SAFE_ID      = 4'hE
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       req_valid,
   input  logic [3:0] req_id,
   output logic       req_ready,
   output logic [3:0] sel_id,
   output logic       sel_clk,
   output logic       design_rst,
   output logic       busy,
   output logic [3:0] cur_id,
   output logic       cur_valid,
   output logic       done,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      GUARD   = 3'd3,
      N_SETUP = 3'd4,
      N_PULSE = 3'd5,
      N_HOLD  = 3'd6
   } state_t;

   // Each state loads the counter with its length minus one on entry and
   // leaves when the counter reaches zero.
   localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] PULSE_LD = 16'(PULSE_CYCLES - 1);
   localparam logic [15:0] GUARD_LD = 16'(GUARD_CYCLES - 1);

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [3:0]  cap_id;
   logic [3:0]  sel_id_n;
   logic        accept;
   logic        finish;
   logic        last;

   assign last      = (cnt == 16'd0);
   assign dbg_state = state;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_n = S_SETUP;
               cnt_n   = SETUP_LD;
            end
         end
         S_SETUP: begin
            if (last) begin
               state_n = S_PULSE;
               cnt_n   = PULSE_LD;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         S_PULSE: begin
            if (last) begin
               state_n = GUARD;
               cnt_n   = GUARD_LD;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         GUARD: begin
            if (last) begin
               state_n = N_SETUP;
               cnt_n   = SETUP_LD;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         N_SETUP: begin
            if (last) begin
               state_n = N_PULSE;
               cnt_n   = PULSE_LD;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         N_PULSE: begin
            if (last) begin
               state_n = N_HOLD;
               cnt_n   = SETUP_LD;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         N_HOLD: begin
            if (last) begin
               state_n = IDLE;
               cnt_n   = 16'd0;
               finish  = 1'b1;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 16'd0;
         end
      endcase
   end

   // sel_id only changes on entry to S_SETUP or N_SETUP. sel_clk is low on
   // both sides of those transitions, so the mux never sees sel_id move
   // around a strobe edge. In IDLE the last driven value is held.
   always_comb begin
      sel_id_n = sel_id;
      case (state_n)
         S_SETUP, S_PULSE, GUARD:  sel_id_n = SAFE_ID;
         N_SETUP, N_PULSE, N_HOLD: sel_id_n = cap_id;
         default:                  sel_id_n = sel_id;
      endcase
   end

   // Outputs are registered from the next-state decode, so they line up
   // with the state they describe.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         cnt        <= 16'd0;
         cap_id     <= 4'd0;
         sel_clk    <= 1'b0;
         sel_id     <= SAFE_ID;
         design_rst <= 1'b0;
         busy       <= 1'b0;
         req_ready  <= 1'b1;
         done       <= 1'b0;
         cur_id     <= 4'd0;
         cur_valid  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         if (accept) begin
            cap_id <= req_id;
         end
         sel_clk    <= (state_n == S_PULSE) || (state_n == N_PULSE);
         sel_id     <= sel_id_n;
         design_rst <= (state_n != IDLE);
         busy       <= (state_n != IDLE);
         req_ready  <= (state_n == IDLE);
         done       <= finish;
         if (finish) begin
            cur_id    <= cap_id;
            cur_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_design_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_design_sel_ctrl
//
// Two instances share one clock. Instance 0 uses the default timing.
// Instance 1 uses SETUP/PULSE/GUARD = 1.
//
// Each scoreboard entry packs the following fields:
//   {busy_len[7:0], drst_len[7:0], npulse[3:0], pulse0_id, pulse1_id, cur_id}
// ---------------------------------------------------------------------------
module tb_design_sel_ctrl;

   localparam int W = 32;

   logic       clk;
   logic       rst_w        [2];
   logic       req_valid_w  [2];
   logic [3:0] req_id_w     [2];
   logic       req_ready_w  [2];
   logic [3:0] sel_id_w     [2];
   logic       sel_clk_w    [2];
   logic       design_rst_w [2];
   logic       busy_w       [2];
   logic [3:0] cur_id_w     [2];
   logic       cur_valid_w  [2];
   logic       done_w       [2];
   logic [2:0] dbg_w        [2];

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   int vectors;
   int miscompares;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   design_sel_ctrl dut0 (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst_w[0]),
      .req_valid  (req_valid_w[0]),
      .req_id     (req_id_w[0]),
      .req_ready  (req_ready_w[0]),
      .sel_id     (sel_id_w[0]),
      .sel_clk    (sel_clk_w[0]),
      .design_rst (design_rst_w[0]),
      .busy       (busy_w[0]),
      .cur_id     (cur_id_w[0]),
      .cur_valid  (cur_valid_w[0]),
      .done       (done_w[0]),
      .dbg_state  (dbg_w[0])
   );

   design_sel_ctrl #(
      .SETUP_CYCLES (1),
      .PULSE_CYCLES (1),
      .GUARD_CYCLES (1)
   ) dut1 (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst_w[1]),
      .req_valid  (req_valid_w[1]),
      .req_id     (req_id_w[1]),
      .req_ready  (req_ready_w[1]),
      .sel_id     (sel_id_w[1]),
      .sel_clk    (sel_clk_w[1]),
      .design_rst (design_rst_w[1]),
      .busy       (busy_w[1]),
      .cur_id     (cur_id_w[1]),
      .cur_valid  (cur_valid_w[1]),
      .done       (done_w[1]),
      .dbg_state  (dbg_w[1])
   );

   function automatic logic [W-1:0] mk(input int b, input int d, input int np,
                                       input logic [3:0] p0, input logic [3:0] p1,
                                       input logic [3:0] c);
      logic [7:0] b8;
      logic [7:0] d8;
      logic [3:0] n4;
      b8 = b[7:0];
      d8 = d[7:0];
      n4 = np[3:0];
      return {b8, d8, n4, p0, p1, c};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int         busy_cnt  [2];
   int         drst_cnt  [2];
   int         npulse    [2];
   logic [3:0] p0_id     [2];
   logic [3:0] p1_id     [2];
   logic       prev_clk  [2];
   logic [3:0] prev_id   [2];
   logic       prev_done [2];
   logic       prev_rst  [2];

   task automatic clear_trk(input int k);
      busy_cnt[k] = 0;
      drst_cnt[k] = 0;
      npulse[k]   = 0;
      p0_id[k]    = 4'd0;
      p1_id[k]    = 4'd0;
   endtask

   task automatic mon_step(input int k);
      logic [W-1:0] act;
      logic [W-1:0] exp;
      if (rst_w[k]) begin
         clear_trk(k);
         prev_rst[k]  = 1'b1;
         prev_clk[k]  = sel_clk_w[k];
         prev_id[k]   = sel_id_w[k];
         prev_done[k] = 1'b0;
         return;
      end
      if (!prev_rst[k] && (sel_id_w[k] !== prev_id[k]) && (sel_clk_w[k] || prev_clk[k])) begin
         miscompares++;
         $display("FAIL sel_id_stable dut%0d: sel_id %h -> %h with sel_clk %b -> %b",
                  k, prev_id[k], sel_id_w[k], prev_clk[k], sel_clk_w[k]);
      end
      if (done_w[k] && prev_done[k]) begin
         miscompares++;
         $display("FAIL done_width dut%0d: done high 2 cycles, required 1", k);
      end
      if (busy_w[k])       busy_cnt[k]++;
      if (design_rst_w[k]) drst_cnt[k]++;
      if (sel_clk_w[k] && !prev_clk[k]) begin
         if (npulse[k] == 0)      p0_id[k] = sel_id_w[k];
         else if (npulse[k] == 1) p1_id[k] = sel_id_w[k];
         if (npulse[k] < 15) npulse[k]++;
      end
      if (done_w[k]) begin
         act = mk(busy_cnt[k], drst_cnt[k], npulse[k], p0_id[k], p1_id[k], cur_id_w[k]);
         vectors++;
         if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            miscompares++;
            $display("FAIL unexpected_done dut%0d: got %h, required no done", k, act);
         end else begin
            if (k == 0) exp = exp_q0.pop_front();
            else        exp = exp_q1.pop_front();
            if (act !== exp || cur_valid_w[k] !== 1'b1) begin
               miscompares++;
               $display("FAIL sequence dut%0d: got %h cur_valid %b, required %h cur_valid 1",
                        k, act, cur_valid_w[k], exp);
            end
         end
         clear_trk(k);
      end
      prev_rst[k]  = 1'b0;
      prev_clk[k]  = sel_clk_w[k];
      prev_id[k]   = sel_id_w[k];
      prev_done[k] = done_w[k];
   endtask

   always @(negedge clk) begin
      mon_step(0);
      mon_step(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Issue a one-cycle request whose accept edge is the next posedge.
   task automatic issue(input int k, input logic [3:0] id);
      req_valid_w[k] = 1'b1;
      req_id_w[k]    = id;
      tick();
      req_valid_w[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done_w[k]) return;
      end
      miscompares++;
      $display("FAIL done_timeout dut%0d: no done within %0d cycles", k, bound);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rises;
      logic pc;
      logic seen;
      vectors     = 0;
      miscompares = 0;
      for (int k = 0; k < 2; k++) begin
         rst_w[k]       = 1'b1;
         req_valid_w[k] = 1'b0;
         req_id_w[k]    = 4'd0;
         clear_trk(k);
         prev_clk[k]  = 1'b0;
         prev_id[k]   = 4'hE;
         prev_done[k] = 1'b0;
         prev_rst[k]  = 1'b1;
      end
      repeat (3) tick();
      rst_w[0] = 1'b0;
      rst_w[1] = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_sel_clk",    W'(sel_clk_w[0]),    W'(1'b0));
      chk("rst_sel_id",     W'(sel_id_w[0]),     W'(4'hE));
      chk("rst_design_rst", W'(design_rst_w[0]), W'(1'b0));
      chk("rst_busy",       W'(busy_w[0]),       W'(1'b0));
      chk("rst_done",       W'(done_w[0]),       W'(1'b0));
      chk("rst_cur_id",     W'(cur_id_w[0]),     W'(4'h0));
      chk("rst_cur_valid",  W'(cur_valid_w[0]),  W'(1'b0));
      chk("rst_req_ready",  W'(req_ready_w[0]),  W'(1'b1));

      // Request ID 0: pulses E then 0, 26 busy cycles
      tick();
      exp_q0.push_back(mk(26, 26, 2, 4'hE, 4'h0, 4'h0));
      issue(0, 4'h0);
      @(negedge clk);
      chk("accept_busy",      W'(busy_w[0]),       W'(1'b1));
      chk("accept_drst",      W'(design_rst_w[0]), W'(1'b1));
      chk("accept_req_ready", W'(req_ready_w[0]),  W'(1'b0));
      wait_done(0, 40);
      chk("id0_cur_id",    W'(cur_id_w[0]),    W'(4'h0));
      chk("id0_cur_valid", W'(cur_valid_w[0]), W'(1'b1));
      chk("id0_drst_low",  W'(design_rst_w[0]), W'(1'b0));

      // Request F; a request for 3 during busy is ignored; then 3 is held
      // through completion and accepted in the done cycle.
      tick();
      exp_q0.push_back(mk(26, 26, 2, 4'hE, 4'hF, 4'hF));
      exp_q0.push_back(mk(26, 26, 2, 4'hE, 4'h3, 4'h3));
      issue(0, 4'hF);
      repeat (9) tick();
      issue(0, 4'h3);
      req_id_w[0] = 4'h0;
      repeat (9) tick();
      req_valid_w[0] = 1'b1;
      req_id_w[0]    = 4'h3;
      wait_done(0, 40);
      chk("f_cur_id",       W'(cur_id_w[0]),    W'(4'hF));
      chk("f_done_ready",   W'(req_ready_w[0]), W'(1'b1));
      tick();
      req_valid_w[0] = 1'b0;
      @(negedge clk);
      chk("b2b_busy",       W'(busy_w[0]),      W'(1'b1));
      chk("b2b_req_ready",  W'(req_ready_w[0]), W'(1'b0));
      wait_done(0, 40);
      chk("b2b_cur_id",     W'(cur_id_w[0]),    W'(4'h3));

      // Request 5, reset while sel_clk is high in the second pulse
      tick();
      issue(0, 4'h5);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (sel_clk_w[0] && sel_id_w[0] == 4'h5) seen = 1'b1;
      end
      chk("abort_reach_npulse", W'(seen), W'(1'b1));
      #1;
      rst_w[0] = 1'b1;
      @(negedge clk);
      chk("abort_sel_clk",   W'(sel_clk_w[0]),    W'(1'b0));
      chk("abort_sel_id",    W'(sel_id_w[0]),     W'(4'hE));
      chk("abort_drst",      W'(design_rst_w[0]), W'(1'b0));
      chk("abort_cur_valid", W'(cur_valid_w[0]),  W'(1'b0));
      chk("abort_busy",      W'(busy_w[0]),       W'(1'b0));
      #1;
      rst_w[0] = 1'b0;
      rises = 0;
      pc    = sel_clk_w[0];
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sel_clk_w[0] && !pc) rises++;
         pc = sel_clk_w[0];
      end
      chk("abort_no_rises", W'(rises), W'(0));

      // Request SAFE_ID: both pulses carry E
      tick();
      exp_q0.push_back(mk(26, 26, 2, 4'hE, 4'hE, 4'hE));
      issue(0, 4'hE);
      wait_done(0, 40);
      chk("safe_cur_id",    W'(cur_id_w[0]),    W'(4'hE));
      chk("safe_cur_valid", W'(cur_valid_w[0]), W'(1'b1));

      // Short timing instance: 6 busy cycles, same pulse order
      tick();
      exp_q1.push_back(mk(6, 6, 2, 4'hE, 4'hA, 4'hA));
      issue(1, 4'hA);
      wait_done(1, 20);
      chk("fast_cur_id", W'(cur_id_w[1]), W'(4'hA));
      tick();
      exp_q1.push_back(mk(6, 6, 2, 4'hE, 4'h3, 4'h3));
      issue(1, 4'h3);
      wait_done(1, 20);
      chk("fast2_cur_id", W'(cur_id_w[1]), W'(4'h3));

      repeat (4) tick();
      chk("q0_empty", W'(exp_q0.size()), W'(0));
      chk("q1_empty", W'(exp_q1.size()), W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
